// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the byte-lane data memory:
//   - FUNCT3 load/store size encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FAULT_CAUSE encodings
//   - lane_enables()    : byte-enable mask for a store of a given size/lane
//   - store_replicate() : spreads SB/SH data across all lanes
//   - byte_of()         : selects one byte lane of a word
//   - load_extend()     : extracts and sign/zero-extends a load result
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_CONFLICT = 2'b11;

  // Byte enables for a store. Unsized/illegal encodings enable nothing;
  // those requests are flagged as faults anyway.
  function automatic logic [3:0] lane_enables(input logic [2:0] funct3,
                                              input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << lane;
      F3_H, F3_HU: be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // SB/SH data is replicated so every enabled lane sees the right bits
  // without a lane-dependent shifter.
  function automatic logic [31:0] store_replicate(input logic [31:0] data,
                                                  input logic [2:0]  funct3);
    logic [31:0] rep;
    case (funct3)
      F3_B, F3_BU: rep = {4{data[7:0]}};
      F3_H, F3_HU: rep = {2{data[15:0]}};
      default:     rep = data;
    endcase
    return rep;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] word,
                                         input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Illegal encodings return zero; a faulting load also carries a zero word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = byte_of(word, lane);
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_BU:   res = {24'h000000, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_HU:   res = {16'h0000, h};
      F3_W:    res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_fault_check.sv
// ---------------------------------------------------------------------------
// dmem_fault_check
// Combinational request decoder: computes the word index and byte lane of a
// request and classifies it, in priority order, as a read/write conflict,
// out-of-range, or misaligned (illegal FUNCT3 counts as misaligned).
// Ports:
//   address   in  ADDR_W   byte address of the request
//   mem_read  in  1        load request
//   mem_write in  1        store request
//   funct3    in  3        access size / extension
//   fault     out 1        request is present and faulting
//   cause     out 2        fault cause (CAUSE_NONE when no fault)
//   idx       out IDX_W    word index into the array
//   lane      out 2        byte lane within the word
// ---------------------------------------------------------------------------
module dmem_fault_check
  import dmem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 128,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic [ADDR_W-1:0] address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  output logic              fault,
  output logic [1:0]        cause,
  output logic [IDX_W-1:0]  idx,
  output logic [1:0]        lane
);

  // One extra bit so the span comparison cannot wrap for large depths.
  localparam logic [ADDR_W:0] SPAN_BYTES = (ADDR_W+1)'(4 * DEPTH_WORDS);

  logic [ADDR_W-1:0] offset;
  logic              below_base;
  logic              above_top;
  logic              conflict;
  logic              out_of_range;
  logic              misaligned;
  logic              request;

  assign offset       = address - BASE_ADDR;
  assign below_base   = address < BASE_ADDR;
  assign above_top    = {1'b0, offset} >= SPAN_BYTES;
  assign idx          = offset[2 +: IDX_W];
  assign lane         = offset[1:0];

  assign request      = mem_read | mem_write;
  assign conflict     = mem_read & mem_write;
  assign out_of_range = below_base | above_top;

  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = lane[0];
      F3_W:        misaligned = (lane != 2'b00);
      default:     misaligned = 1'b1;
    endcase
  end

  always_comb begin
    fault = 1'b0;
    cause = CAUSE_NONE;
    if (request) begin
      if (conflict) begin
        fault = 1'b1;
        cause = CAUSE_CONFLICT;
      end else if (out_of_range) begin
        fault = 1'b1;
        cause = CAUSE_RANGE;
      end else if (misaligned) begin
        fault = 1'b1;
        cause = CAUSE_MISALIGN;
      end
    end
  end

endmodule

// File: rtl/dmem_bytelane.sv
// ---------------------------------------------------------------------------
// dmem_bytelane
// RV32 data memory for the MEM stage: byte/half/word stores with byte
// enables, sign/zero-extended loads with a one-cycle registered read, fault
// detection (conflict / out-of-range / misaligned) and a sticky fault record.
// Optional feature macro: DMEM_STORE_FWD_EN
//   defined   : a registered copy of the last store is merged over the array
//               read in the following cycle (for read-first BRAM mapping)
//   undefined : behavioural write-first array, no forwarding register
// Ports:
//   CLK                     in  1       rising-edge clock
//   RST_N                   in  1       asynchronous active-low reset
//   ADDRESS                 in  ADDR_W  byte address
//   WRITE_DATA              in  32      store data (low bytes for SB/SH)
//   MemRead                 in  1       load request
//   MemWrite                in  1       store request
//   FUNCT3                  in  3       access size / extension
//   FAULT_CLR               in  1       clears the sticky fault record
//   READ_DATA               out 32      extended load result
//   READ_VALID              out 1       pulse one cycle after each load
//   SEGMENTATION_FAULT_DMEM out 1       pulse one cycle after a fault
//   FAULT_STICKY            out 1       set by a fault, held until cleared
//   FAULT_ADDR              out ADDR_W  address of first recorded fault
//   FAULT_CAUSE             out 2       cause of first recorded fault
// ---------------------------------------------------------------------------
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 128,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [31:0]       WRITE_DATA,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        FUNCT3,
  input  logic              FAULT_CLR,
  output logic [31:0]       READ_DATA,
  output logic              READ_VALID,
  output logic              SEGMENTATION_FAULT_DMEM,
  output logic              FAULT_STICKY,
  output logic [ADDR_W-1:0] FAULT_ADDR,
  output logic [1:0]        FAULT_CAUSE
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  // Stage p0: request decode (combinational, same cycle as the request)
  logic             fault_p0;
  logic [1:0]       cause_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [1:0]       lane_p0;
  logic             store_p0;
  logic [3:0]       be_p0;
  logic [31:0]      wdata_p0;
  logic [31:0]      rd_word_p0;

  // Stage p1: registered read result and fault pulse
  logic             vld_p1;
  logic             seg_p1;
  logic [31:0]      word_p1;
  logic [1:0]       lane_p1;
  logic [2:0]       f3_p1;

  dmem_fault_check #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .IDX_W       (IDX_W)
  ) u_fault_check (
    .address   (ADDRESS),
    .mem_read  (MemRead),
    .mem_write (MemWrite),
    .funct3    (FUNCT3),
    .fault     (fault_p0),
    .cause     (cause_p0),
    .idx       (idx_p0),
    .lane      (lane_p0)
  );

  // A store coinciding with reset assertion is dropped, so RST_N gates it.
  assign store_p0 = MemWrite & ~fault_p0 & RST_N;
  assign be_p0    = store_p0 ? lane_enables(FUNCT3, lane_p0) : 4'b0000;
  assign wdata_p0 = store_replicate(WRITE_DATA, FUNCT3);

  // Array: no reset, byte-lane write enables.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (be_p0[i]) begin
        mem[idx_p0][8*i +: 8] <= wdata_p0[8*i +: 8];
      end
    end
  end

`ifdef DMEM_STORE_FWD_EN
  logic [IDX_W-1:0] fwd_idx_p1;
  logic [3:0]       fwd_be_p1;
  logic [31:0]      fwd_data_p1;

  // Enables are cleared when no store happens, so the merge only ever
  // applies in the single cycle following a store.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fwd_be_p1 <= 4'b0000;
    end else begin
      fwd_be_p1 <= be_p0;
    end
  end

  always_ff @(posedge CLK) begin
    fwd_idx_p1  <= idx_p0;
    fwd_data_p1 <= wdata_p0;
  end

  always_comb begin
    rd_word_p0 = mem[idx_p0];
    if (fwd_idx_p1 == idx_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (fwd_be_p1[i]) begin
          rd_word_p0[8*i +: 8] = fwd_data_p1[8*i +: 8];
        end
      end
    end
  end
`else
  assign rd_word_p0 = mem[idx_p0];
`endif

  // ---- p0 -> p1 boundary: read pipeline register ----
  // Word, lane and FUNCT3 only update on a load, so READ_DATA holds its
  // value between loads. A faulting load captures a zero word, which
  // extends to zero for every FUNCT3.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1  <= 1'b0;
      seg_p1  <= 1'b0;
      word_p1 <= 32'h0000_0000;
      lane_p1 <= 2'b00;
      f3_p1   <= F3_B;
    end else begin
      vld_p1 <= MemRead;
      seg_p1 <= fault_p0;
      if (MemRead) begin
        word_p1 <= fault_p0 ? 32'h0000_0000 : rd_word_p0;
        lane_p1 <= lane_p0;
        f3_p1   <= FUNCT3;
      end
    end
  end

  assign READ_VALID              = vld_p1;
  assign SEGMENTATION_FAULT_DMEM = seg_p1;
  assign READ_DATA               = load_extend(word_p1, f3_p1, lane_p1);

  // Sticky fault record. A clear arriving with a new fault drops the old
  // record and captures the new one in the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FAULT_STICKY <= 1'b0;
      FAULT_ADDR   <= '0;
      FAULT_CAUSE  <= CAUSE_NONE;
    end else if (fault_p0 && (!FAULT_STICKY || FAULT_CLR)) begin
      FAULT_STICKY <= 1'b1;
      FAULT_ADDR   <= ADDRESS;
      FAULT_CAUSE  <= cause_p0;
    end else if (FAULT_CLR) begin
      FAULT_STICKY <= 1'b0;
      FAULT_ADDR   <= '0;
      FAULT_CAUSE  <= CAUSE_NONE;
    end
  end

endmodule
